// File: rtl/rr_mux2_arbiter.sv
// rr_mux2_arbiter: round-robin 2:1 valid/ready arbiter with registered output stage and saturating grant counters
module rr_mux2_arbiter #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sel,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state;
  logic   rr_ptr;
  logic   can_load;
  logic   gnt_a;
  logic   gnt_b;
  always_comb begin
    can_load = (state == EMPTY) || out_ready;
    gnt_a    = !rst && can_load && a_valid && (!b_valid || !rr_ptr);
    gnt_b    = !rst && can_load && b_valid && (!a_valid || rr_ptr);
  end
  assign a_ready   = gnt_a;
  assign b_ready   = gnt_b;
  assign out_valid = (state == FULL);
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      out_data <= '0;
      out_sel  <= 1'b0;
      rr_ptr   <= 1'b0;
      cnt_a    <= '0;
      cnt_b    <= '0;
    end else if (gnt_a || gnt_b) begin
      state    <= FULL;
      out_data <= gnt_b ? b_data : a_data;
      out_sel  <= gnt_b;
      rr_ptr   <= gnt_a;
      cnt_a    <= cnt_a + CNT_W'(gnt_a && !(&cnt_a));
      cnt_b    <= cnt_b + CNT_W'(gnt_b && !(&cnt_b));
    end else if (out_ready) begin
      state <= EMPTY;
    end
  end
endmodule

// File: tb/tb_rr_mux2_arbiter.sv
// tb_rr_mux2_arbiter: table-driven self-checking bench for rr_mux2_arbiter
module tb_rr_mux2_arbiter;
  typedef struct {
    logic       rst;
    logic       av;
    logic [7:0] ad;
    logic       bv;
    logic [7:0] bd;
    logic       ordy;
    logic       ar;
    logic       br;
    logic       ov;
    logic [7:0] od;
    logic       sel;
    logic [7:0] ca;
    logic [7:0] cb;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst, a_valid, b_valid, out_ready;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready, out_valid, out_sel;
  logic [7:0] out_data, cnt_a, cnt_b;
  logic       s_rst, s_a_valid, s_b_valid, s_out_ready;
  logic [7:0] s_a_data, s_b_data;
  logic       s_a_ready, s_b_ready, s_out_valid, s_out_sel;
  logic [7:0] s_out_data;
  logic [1:0] s_cnt_a, s_cnt_b;
  int         n_vec = 0;
  int         n_bad = 0;
  vec_t       v[24];
  always #5 clk = ~clk;
  rr_mux2_arbiter #(.DATA_W(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready),
    .cnt_a(cnt_a), .cnt_b(cnt_b)
  );
  rr_mux2_arbiter #(.DATA_W(8), .CNT_W(2)) u_sat (
    .clk(clk), .rst(s_rst),
    .a_valid(s_a_valid), .a_data(s_a_data), .a_ready(s_a_ready),
    .b_valid(s_b_valid), .b_data(s_b_data), .b_ready(s_b_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_sel(s_out_sel), .out_ready(s_out_ready),
    .cnt_a(s_cnt_a), .cnt_b(s_cnt_b)
  );
  function automatic vec_t mk(logic r, logic av, logic [7:0] ad, logic bv, logic [7:0] bd, logic ordy,
                              logic ar, logic br, logic ov, logic [7:0] od, logic sel, logic [7:0] ca, logic [7:0] cb);
    vec_t t;
    t.rst = r; t.av = av; t.ad = ad; t.bv = bv; t.bd = bd; t.ordy = ordy;
    t.ar = ar; t.br = br; t.ov = ov; t.od = od; t.sel = sel; t.ca = ca; t.cb = cb;
    return t;
  endfunction
  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask
  initial begin
    v[0]  = mk(1, 1, 8'h01, 1, 8'h02, 1,  0, 0, 0, 8'h00, 0, 0, 0);
    v[1]  = mk(1, 1, 8'h01, 1, 8'h02, 1,  0, 0, 0, 8'h00, 0, 0, 0);
    v[2]  = mk(0, 1, 8'h11, 0, 8'h00, 1,  1, 0, 1, 8'h11, 0, 1, 0);
    v[3]  = mk(0, 1, 8'h22, 0, 8'h00, 1,  1, 0, 1, 8'h22, 0, 2, 0);
    v[4]  = mk(0, 1, 8'h33, 0, 8'h00, 1,  1, 0, 1, 8'h33, 0, 3, 0);
    v[5]  = mk(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 8'h33, 0, 3, 0);
    v[6]  = mk(1, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 8'h00, 0, 0, 0);
    v[7]  = mk(0, 1, 8'hA0, 1, 8'hB0, 1,  1, 0, 1, 8'hA0, 0, 1, 0);
    v[8]  = mk(0, 1, 8'hA1, 1, 8'hB1, 1,  0, 1, 1, 8'hB1, 1, 1, 1);
    v[9]  = mk(0, 1, 8'hA2, 1, 8'hB2, 1,  1, 0, 1, 8'hA2, 0, 2, 1);
    v[10] = mk(0, 1, 8'hA3, 1, 8'hB3, 1,  0, 1, 1, 8'hB3, 1, 2, 2);
    v[11] = mk(0, 1, 8'hA4, 1, 8'hB4, 1,  1, 0, 1, 8'hA4, 0, 3, 2);
    v[12] = mk(0, 1, 8'hA5, 1, 8'hB5, 1,  0, 1, 1, 8'hB5, 1, 3, 3);
    v[13] = mk(0, 0, 8'h00, 1, 8'h5A, 1,  0, 1, 1, 8'h5A, 1, 3, 4);
    v[14] = mk(0, 1, 8'h77, 0, 8'h00, 0,  0, 0, 1, 8'h5A, 1, 3, 4);
    v[15] = mk(0, 1, 8'h77, 0, 8'h00, 0,  0, 0, 1, 8'h5A, 1, 3, 4);
    v[16] = mk(0, 1, 8'h77, 0, 8'h00, 0,  0, 0, 1, 8'h5A, 1, 3, 4);
    v[17] = mk(0, 1, 8'h77, 0, 8'h00, 0,  0, 0, 1, 8'h5A, 1, 3, 4);
    v[18] = mk(0, 1, 8'h77, 0, 8'h00, 1,  1, 0, 1, 8'h77, 0, 4, 4);
    v[19] = mk(1, 1, 8'h99, 1, 8'h98, 0,  0, 0, 0, 8'h00, 0, 0, 0);
    v[20] = mk(0, 1, 8'hC1, 1, 8'hD1, 1,  1, 0, 1, 8'hC1, 0, 1, 0);
    v[21] = mk(0, 1, 8'hC2, 1, 8'hD2, 1,  0, 1, 1, 8'hD2, 1, 1, 1);
    v[22] = mk(0, 1, 8'hC3, 1, 8'hD3, 0,  0, 0, 1, 8'hD2, 1, 1, 1);
    v[23] = mk(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 8'hD2, 1, 1, 1);
    rst = 1; a_valid = 0; b_valid = 0; a_data = 0; b_data = 0; out_ready = 0;
    s_rst = 1; s_a_valid = 0; s_b_valid = 0; s_a_data = 0; s_b_data = 0; s_out_ready = 1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      rst = v[i].rst; a_valid = v[i].av; a_data = v[i].ad;
      b_valid = v[i].bv; b_data = v[i].bd; out_ready = v[i].ordy;
      #1;
      check("a_ready", i, 32'(a_ready), 32'(v[i].ar));
      check("b_ready", i, 32'(b_ready), 32'(v[i].br));
      @(posedge clk);
      #1;
      check("out_valid", i, 32'(out_valid), 32'(v[i].ov));
      if (v[i].ov || v[i].rst) begin
        check("out_data", i, 32'(out_data), 32'(v[i].od));
        check("out_sel", i, 32'(out_sel), 32'(v[i].sel));
      end
      check("cnt_a", i, 32'(cnt_a), 32'(v[i].ca));
      check("cnt_b", i, 32'(cnt_b), 32'(v[i].cb));
    end
    @(negedge clk);
    s_rst = 0; s_a_valid = 1;
    for (int i = 0; i < 5; i++) begin
      s_a_data = 8'(8'h40 + i);
      #1;
      check("sat_a_ready", i, 32'(s_a_ready), 32'd1);
      @(posedge clk);
      #1;
      check("sat_cnt_a", i, 32'(s_cnt_a), (i < 3) ? 32'(i + 1) : 32'd3);
      check("sat_out_data", i, 32'(s_out_data), 32'(8'h40 + i));
      check("sat_cnt_b", i, 32'(s_cnt_b), 32'd0);
      @(negedge clk);
    end
    s_a_valid = 0; s_b_valid = 1; s_b_data = 8'hEE;
    #1;
    check("sat_b_ready", 5, 32'(s_b_ready), 32'd1);
    @(posedge clk);
    #1;
    check("sat_b_load", 5, {23'd0, s_out_valid, s_out_data}, {23'd0, 1'b1, 8'hEE});
    check("sat_cnt_b", 5, 32'(s_cnt_b), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
